inv_transmission_divider: RTL and testbench

INV_TRANSMISSION_DIVIDER -- requirements
Module: inv_transmission_divider

---
 rtl/inv_transmission_divider.sv | 106 ++++++++++
 tb/tb_inv_transmission_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inv_transmission_divider.sv
// Reciprocal of a Q0.8 transmission sample, delivered as Q2.14.
// The division is a serial restoring divider that produces one quotient bit
// per cycle, MSB first. A 24-bit sideband tag travels with each sample.
module inv_transmission_divider #(
  parameter int unsigned T_MIN = 65
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  trans,
  input  logic [23:0] tag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] inv_trans,
  output logic [23:0] tag_out,
  output logic        sat
);

  localparam logic [7:0] TMIN8 = 8'(T_MIN);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  d;       // clamped divisor, never zero
  logic [22:0] work;    // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [7:0]  rem;     // partial remainder, always < d
  logic [4:0]  cnt;     // remaining divide steps minus one
  logic [23:0] tag_q;

  logic [7:0]  dsel;
  logic [22:0] dividend;
  logic [8:0]  rem_sh, rem_sub;
  logic        ge;
  logic [7:0]  rem_nx;
  logic [22:0] q_fin;

  // Divisor clamp and the rounding bias (d/2) folded into the dividend.
  assign dsel     = (trans < TMIN8) ? TMIN8 : trans;
  assign dividend = {1'b1, 22'd0} + {15'd0, dsel[7:1]};

  // One restoring step: shift in the next dividend bit, then subtract if it fits.
  always_comb begin
    rem_sh  = {rem, work[22]};
    rem_sub = rem_sh - {1'b0, d};
    ge      = (rem_sh >= {1'b0, d});
    rem_nx  = ge ? rem_sub[7:0] : rem_sh[7:0];
    q_fin   = {work[21:0], ge};
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: accept, divide until the counter expires, hold until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)   state_nx = DIV;
      DIV:     if (cnt == '0)  state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in DIV, and register results on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d         <= '0;
      work      <= '0;
      rem       <= '0;
      cnt       <= '0;
      tag_q     <= '0;
      inv_trans <= '0;
      tag_out   <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d     <= dsel;
          work  <= dividend;
          rem   <= '0;
          cnt   <= 5'd22;
          tag_q <= tag_in;
        end
        DIV: begin
          work <= q_fin;
          rem  <= rem_nx;
          cnt  <= cnt - 5'd1;
          if (cnt == '0) begin
            sat       <= |q_fin[22:16];
            inv_trans <= (|q_fin[22:16]) ? 16'hFFFF : q_fin[15:0];
            tag_out   <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_transmission_divider.sv
// Directed bench for inv_transmission_divider: table of reciprocal vectors,
// plus sequences for back-pressure, ignored inputs, saturation and mid-divide reset.
module tb_inv_transmission_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  trans;
  logic [23:0] tag_in;
  logic        in_ready, out_valid, sat;
  logic [15:0] inv_trans;
  logic [23:0] tag_out;
  logic        in_ready64, out_valid64, sat64;
  logic [15:0] inv_trans64;
  logic [23:0] tag_out64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  inv_transmission_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .trans(trans), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .inv_trans(inv_trans), .tag_out(tag_out), .sat(sat));

  inv_transmission_divider #(.T_MIN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .trans(trans), .tag_in(tag_in), .out_valid(out_valid64), .out_ready(out_ready),
    .inv_trans(inv_trans64), .tag_out(tag_out64), .sat(sat64));

  typedef struct {
    logic [7:0]  trans;
    logic [23:0] tag;
    logic [15:0] exp_inv;
    logic        exp_sat;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one sample, scramble the inputs, wait for the result. lat counts
  // rising edges with the accepting edge as edge 1.
  task automatic send_and_wait(input logic [7:0] t, input logic [23:0] tg,
                               input logic rdy, output int lat);
    @(posedge clk); #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; trans = t; tag_in = tg; out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0; trans = 8'h01; tag_in = 24'h555555;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] held_inv;

    vt[0] = '{8'd128, 24'hABCDEF, 16'h8000, 1'b0};
    vt[1] = '{8'd255, 24'h000001, 16'd16448, 1'b0};
    vt[2] = '{8'd200, 24'h123456, 16'd20972, 1'b0};
    vt[3] = '{8'd0,   24'hFFFFFF, 16'hFC10, 1'b0};
    vt[4] = '{8'd40,  24'h0F0F0F, 16'hFC10, 1'b0};
    vt[5] = '{8'd65,  24'hA5A5A5, 16'hFC10, 1'b0};
    vt[6] = '{8'd100, 24'h800000, 16'd41943, 1'b0};
    vt[7] = '{8'd129, 24'h13579B, 16'd32514, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; trans = '0; tag_in = '0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inv_trans", {16'd0, inv_trans}, 32'd0);
    check("rst_tag_out",   {8'd0, tag_out},    32'd0);
    check("rst_sat",       {31'd0, sat},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Table: out_ready held high, so each result is consumed the edge after it appears.
    for (int i = 0; i < 8; i++) begin
      send_and_wait(vt[i].trans, vt[i].tag, 1'b1, lat);
      check($sformatf("latency[%0d]", i), lat, 32'd24);
      check($sformatf("inv_trans[%0d]", i), {16'd0, inv_trans}, {16'd0, vt[i].exp_inv});
      check($sformatf("sat[%0d]", i), {31'd0, sat}, {31'd0, vt[i].exp_sat});
      check($sformatf("tag_out[%0d]", i), {8'd0, tag_out}, {8'd0, vt[i].tag});
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("consumed[%0d]", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("in_ready_next[%0d]", i), {31'd0, in_ready}, 32'd1);
    end

    // Saturation: T_MIN=64 instance overflows at trans=64; default instance clamps to 65.
    send_and_wait(8'd64, 24'h646464, 1'b1, lat);
    check("sat64_valid", {31'd0, out_valid64}, 32'd1);
    check("sat64_inv",   {16'd0, inv_trans64}, 32'h0000FFFF);
    check("sat64_sat",   {31'd0, sat64},       32'd1);
    check("sat64_tag",   {8'd0, tag_out64},    32'h00646464);
    check("tmin65_inv",  {16'd0, inv_trans},   32'h0000FC10);
    check("tmin65_sat",  {31'd0, sat},         32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Back-pressure: result holds for 10 cycles, a new in_valid is ignored.
    send_and_wait(8'd200, 24'hC0FFEE, 1'b0, lat);
    check("hold_latency", lat, 32'd24);
    held_inv = inv_trans;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      trans = 8'd128;
      @(posedge clk); #1;
      check($sformatf("hold_valid[%0d]", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold_inv[%0d]", c), {16'd0, inv_trans}, 32'd20972);
      check($sformatf("hold_tag[%0d]", c), {8'd0, tag_out}, 32'h00C0FFEE);
      check($sformatf("hold_in_ready[%0d]", c), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_inv_kept", {16'd0, inv_trans}, {16'd0, held_inv});
    // The in_valid pulse during DONE must not have started a division.
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("ignored_in_valid", lat, 32'd0);

    // Reset mid-divide: outputs clear at once, no stale result afterwards.
    @(posedge clk); #1;
    in_valid = 1'b1; trans = 8'd255; tag_in = 24'hDEAD00; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_inv",       {16'd0, inv_trans}, 32'd0);
    check("midrst_tag",       {8'd0, tag_out},    32'd0);
    check("midrst_sat",       {31'd0, sat},       32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("midrst_no_stale", lat, 32'd0);
    send_and_wait(8'd128, 24'h00BEEF, 1'b1, lat);
    check("post_rst_latency", lat, 32'd24);
    check("post_rst_inv", {16'd0, inv_trans}, 32'h00008000);
    check("post_rst_tag", {8'd0, tag_out}, 32'h0000BEEF);
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
